// File: rtl/pov_spi_tx.sv
// SPI mode-0 master that shifts one 74-bit POV camera frame out MSB first.
// The frame is latched at i_start; o_done pulses once the trailing select-high gap has elapsed.
module pov_spi_tx #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [14:0] i_player_x,
  input  logic [14:0] i_player_y,
  input  logic [10:0] i_facing_x,
  input  logic [10:0] i_facing_y,
  input  logic [10:0] i_vplane_x,
  input  logic [10:0] i_vplane_y,
  output logic        o_sclk,
  output logic        o_ss_n,
  output logic        o_mosi,
  output logic        o_busy,
  output logic        o_done
);

  localparam int MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int DIV_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [DIV_W-1:0] HALF_RELOAD = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] GAP_RELOAD  = DIV_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [6:0]       bit_cnt;
  logic [73:0]      shift_reg;
  logic [73:0]      frame;
  logic             div_zero;

  assign frame    = {i_player_x, i_player_y, i_facing_x, i_facing_y, i_vplane_x, i_vplane_y};
  assign div_zero = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      o_sclk    <= 1'b0;
      o_ss_n    <= 1'b1;
      o_mosi    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= SETUP;
            shift_reg <= frame;
            bit_cnt   <= 7'd73;
            div_cnt   <= HALF_RELOAD;
            o_ss_n    <= 1'b0;
            o_sclk    <= 1'b0;
            o_mosi    <= frame[73];
            o_busy    <= 1'b1;
          end
        end
        SETUP, SHIFT_LO: begin
          if (div_zero) begin
            state   <= SHIFT_HI;
            div_cnt <= HALF_RELOAD;
            o_sclk  <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        SHIFT_HI: begin
          // Data advances only on the falling edge so it is settled around every rise.
          if (div_zero) begin
            div_cnt <= HALF_RELOAD;
            o_sclk  <= 1'b0;
            if (bit_cnt == 7'd0) begin
              state  <= HOLD;
              o_mosi <= 1'b0;
            end else begin
              state     <= SHIFT_LO;
              bit_cnt   <= bit_cnt - 7'd1;
              o_mosi    <= shift_reg[72];
              shift_reg <= {shift_reg[72:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (div_zero) begin
            state   <= GAP;
            div_cnt <= GAP_RELOAD;
            o_ss_n  <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        GAP: begin
          if (div_zero) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pov_spi_tx.sv
// Bench for pov_spi_tx: two instances (H=4/GAP=4 and H=2/GAP=1) with an SPI slave model
// that samples MOSI on SCLK rises and timestamps every select and clock edge.
module tb_pov_spi_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [14:0] px [2];
  logic [14:0] py [2];
  logic [10:0] fx [2];
  logic [10:0] fy [2];
  logic [10:0] vx [2];
  logic [10:0] vy [2];
  logic        start [2];
  logic        sclk [2];
  logic        ss_n [2];
  logic        mosi [2];
  logic        busy [2];
  logic        done [2];

  int errors = 0;
  int checks = 0;
  int pcyc = 0;

  pov_spi_tx #(.HALF_PERIOD(4), .GAP_CYCLES(4)) u_dut0 (
    .clk(clk), .reset(reset), .i_start(start[0]),
    .i_player_x(px[0]), .i_player_y(py[0]), .i_facing_x(fx[0]), .i_facing_y(fy[0]),
    .i_vplane_x(vx[0]), .i_vplane_y(vy[0]),
    .o_sclk(sclk[0]), .o_ss_n(ss_n[0]), .o_mosi(mosi[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  pov_spi_tx #(.HALF_PERIOD(2), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_start(start[1]),
    .i_player_x(px[1]), .i_player_y(py[1]), .i_facing_x(fx[1]), .i_facing_y(fy[1]),
    .i_vplane_x(vx[1]), .i_vplane_y(vy[1]),
    .o_sclk(sclk[1]), .o_ss_n(ss_n[1]), .o_mosi(mosi[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  function automatic int hp(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int gp(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) pcyc <= pcyc + 1;

  // SPI slave model, sampled on the falling clk edge away from output updates.
  int          m_rises  [2] = '{0, 0};
  int          m_tot    [2] = '{0, 0};
  int          m_first  [2] = '{-1, -1};
  int          m_last   [2] = '{-1, -1};
  int          m_ssfall [2] = '{-1, -1};
  int          m_ssrise [2] = '{-1, -1};
  int          m_gap    [2] = '{-1, -1};
  int          m_bad    [2] = '{0, 0};
  logic [73:0] m_cap    [2] = '{74'd0, 74'd0};
  logic        m_psclk  [2] = '{1'b0, 1'b0};
  logic        m_pss    [2] = '{1'b1, 1'b1};
  logic        m_pmosi  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ss_n[d] && !m_pss[d]) m_ssrise[d] = pcyc;
      if (!ss_n[d] && m_pss[d]) begin
        m_ssfall[d] = pcyc;
        m_gap[d]    = pcyc - m_ssrise[d];
        m_rises[d]  = 0;
        m_cap[d]    = '0;
      end
      if (sclk[d] && !m_psclk[d]) begin
        if (m_rises[d] == 0) m_first[d] = pcyc;
        else if (pcyc - m_last[d] != 2 * hp(d)) m_bad[d]++;
        m_last[d]  = pcyc;
        m_rises[d]++;
        m_tot[d]++;
        m_cap[d]   = {m_cap[d][72:0], mosi[d]};
      end
      if (sclk[d] != m_psclk[d] && ss_n[d] && m_pss[d]) m_bad[d]++;
      if (mosi[d] != m_pmosi[d] && !(m_psclk[d] && !sclk[d]) && (ss_n[d] == m_pss[d])) m_bad[d]++;
      m_psclk[d] = sclk[d];
      m_pss[d]   = ss_n[d];
      m_pmosi[d] = mosi[d];
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic run_frame(input int d, input logic [14:0] ax, input logic [14:0] ay,
                           input logic [10:0] bx, input logic [10:0] by,
                           input logic [10:0] cx, input logic [10:0] cy,
                           input bit poke, input bit chain);
    logic [73:0] want;
    int t0, rel, done_rel, h, g;
    h = hp(d);
    g = gp(d);
    want = {ax, ay, bx, by, cx, cy};
    px[d] = ax; py[d] = ay; fx[d] = bx; fy[d] = by; vx[d] = cx; vy[d] = cy;
    start[d] = 1'b1;
    t0 = pcyc;
    done_rel = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rel = pcyc - t0;
      start[d] = poke && (rel == 10 || rel == 300);
      if (poke && rel == 50) begin
        px[d] = 15'($urandom); py[d] = 15'($urandom);
        fx[d] = 11'($urandom); fy[d] = 11'($urandom);
        vx[d] = 11'($urandom); vy[d] = 11'($urandom);
      end
      if (rel == 1) begin
        chk("setup_ss_n", 80'(ss_n[d]), 80'(0));
        chk("setup_sclk", 80'(sclk[d]), 80'(0));
        chk("setup_busy", 80'(busy[d]), 80'(1));
        chk("setup_mosi", 80'(mosi[d]), 80'(want[73]));
      end
      if (done[d]) begin
        done_rel = rel;
        break;
      end
    end
    chk("done_cycle", 80'(done_rel), 80'(1 + 149 * h + g));
    chk("done_busy_low", 80'(busy[d]), 80'(0));
    chk("frame_captured", 80'(m_cap[d]), 80'(want));
    chk("rise_count", 80'(m_rises[d]), 80'(74));
    chk("first_rise", 80'(m_first[d] - t0), 80'(1 + h));
    chk("last_rise", 80'(m_last[d] - t0), 80'(1 + 147 * h));
    chk("ss_fall", 80'(m_ssfall[d] - t0), 80'(1));
    chk("ss_rise", 80'(m_ssrise[d] - t0), 80'(1 + 149 * h));
    if (!chain) begin
      @(negedge clk);
      chk("done_one_cycle", 80'(done[d]), 80'(0));
    end
  endtask

  task automatic run_random(input int d, input bit poke, input bit chain);
    run_frame(d, 15'($urandom), 15'($urandom), 11'($urandom), 11'($urandom),
              11'($urandom), 11'($urandom), poke, chain);
  endtask

  initial begin
    int t0, dcount, snap;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      px[d] = '0; py[d] = '0; fx[d] = '0; fy[d] = '0; vx[d] = '0; vy[d] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ss_n", 80'(ss_n[d]), 80'(1));
      chk("rst_sclk", 80'(sclk[d]), 80'(0));
      chk("rst_mosi", 80'(mosi[d]), 80'(0));
      chk("rst_busy", 80'(busy[d]), 80'(0));
      chk("rst_done", 80'(done[d]), 80'(0));
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_rises0", 80'(m_tot[0]), 80'(0));
    chk("idle_no_rises1", 80'(m_tot[1]), 80'(0));

    // Demo frame, then a frame with ignored start pulses and mid-frame input changes.
    run_frame(0, 15'h1700, 15'h1500, 11'h170, 11'h69D, 11'h0B1, 11'h0B8, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    run_random(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    run_random(0, 1'b0, 1'b0);

    // Back-to-back: second start lands in the o_done cycle.
    run_random(0, 1'b0, 1'b1);
    run_random(0, 1'b0, 1'b0);
    chk("b2b_gap", 80'(m_gap[0]), 80'(gp(0) + 1));

    // Reset in the middle of a frame.
    repeat (4) @(negedge clk);
    px[0] = 15'($urandom); py[0] = 15'($urandom);
    start[0] = 1'b1;
    t0 = pcyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (pcyc - t0 == 200) break;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ss_n", 80'(ss_n[0]), 80'(1));
    chk("midrst_sclk", 80'(sclk[0]), 80'(0));
    chk("midrst_mosi", 80'(mosi[0]), 80'(0));
    chk("midrst_busy", 80'(busy[0]), 80'(0));
    chk("midrst_done", 80'(done[0]), 80'(0));
    snap = m_tot[0];
    dcount = 0;
    repeat (700) begin
      @(negedge clk);
      if (done[0]) dcount++;
    end
    chk("midrst_no_done", 80'(dcount), 80'(0));
    chk("midrst_no_rises", 80'(m_tot[0] - snap), 80'(0));
    run_random(0, 1'b0, 1'b0);

    // Fastest configuration on the second instance.
    run_frame(1, 15'h1700, 15'h1500, 11'h170, 11'h69D, 11'h0B1, 11'h0B8, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_random(1, 1'b0, 1'b1);
    run_random(1, 1'b0, 1'b0);
    chk("b2b_gap_h2", 80'(m_gap[1]), 80'(gp(1) + 1));

    chk("edge_rules0", 80'(m_bad[0]), 80'(0));
    chk("edge_rules1", 80'(m_bad[1]), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
